// File: rtl/dot_product_accumulator_if.sv
// Handshake bundle for the dot-product accumulator: a product-beat stream in
// and a result stream out, each with its own valid/ready pair.
interface dot_product_accumulator_if #(
  parameter int ACC_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_product;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [4:0]       out_count;
  logic             out_overflow;

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow
  );

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow
  );
endinterface

// File: rtl/dot_product_accumulator.sv
// Sums up to N_TERMS unsigned 8-bit product beats into an ACC_W-bit result
// with a sticky carry flag, then holds the result until downstream takes it.
module dot_product_accumulator #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  dot_product_accumulator_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [4:0]       r_count;
  logic             r_ovf;
  logic [ACC_W-1:0] r_out_sum;
  logic [4:0]       r_out_count;
  logic             r_out_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_term;
  logic [ACC_W:0]   w_sum;
  logic [4:0]       w_count_nxt;
  logic             w_ovf_nxt;

  // The first beat of a dot product restarts the sum rather than adding to stale state.
  always_comb begin
    w_accept = bus.in_valid && r_in_ready;
    if (r_state == IDLE) begin
      w_sum       = {{(ACC_W + 1 - 8){1'b0}}, bus.in_product};
      w_count_nxt = 5'd1;
      w_ovf_nxt   = 1'b0;
    end else begin
      w_sum       = {1'b0, r_acc} + {{(ACC_W + 1 - 8){1'b0}}, bus.in_product};
      w_count_nxt = r_count + 5'd1;
      w_ovf_nxt   = r_ovf | w_sum[ACC_W];
    end
    w_term = bus.in_last || (w_count_nxt == 5'(N_TERMS));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, ACCUM: begin
        if (w_accept) begin
          w_state_nxt = w_term ? HOLD : ACCUM;
        end else begin
          w_state_nxt = r_state;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake flags are registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt != HOLD);
      r_out_valid <= (w_state_nxt == HOLD);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= {ACC_W{1'b0}};
      r_count     <= 5'd0;
      r_ovf       <= 1'b0;
      r_out_sum   <= {ACC_W{1'b0}};
      r_out_count <= 5'd0;
      r_out_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= w_sum[ACC_W-1:0];
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
      if (w_term) begin
        r_out_sum   <= w_sum[ACC_W-1:0];
        r_out_count <= w_count_nxt;
        r_out_ovf   <= w_ovf_nxt;
      end
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_sum      = r_out_sum;
  assign bus.out_count    = r_out_count;
  assign bus.out_overflow = r_out_ovf;

endmodule

// File: doc/dot_product_accumulator.md
DOT_PRODUCT_ACCUMULATOR -- requirements
Module: dot_product_accumulator

Interface
REQ-001 SHALL have parameter N_TERMS, default 4, maximum products per dot product (legal 1..16).
REQ-002 SHALL have parameter ACC_W, default 12, accumulator and result width (legal 8..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream presents a product beat.
REQ-006 SHALL have port in_ready  output  1  block can accept a product beat.
REQ-007 SHALL have port in_product  input  8  unsigned 8-bit product from the 4x4 array multiplier.
REQ-008 SHALL have port in_last  input  1  marks the final beat of the current dot product.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port out_sum  output  ACC_W  accumulated sum, modulo 2^ACC_W.
REQ-012 SHALL have port out_count  output  5  number of products summed into out_sum.
REQ-013 SHALL have port out_overflow  output  1  sticky flag: true sum exceeded 2^ACC_W-1.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-015 SHALL define beat acceptance as in_valid && in_ready on a rising clk edge.
REQ-016 SHALL drive in_ready=1 in IDLE and ACCUM, 0 in HOLD.
REQ-017 SHALL, on an accepted beat in IDLE, load acc=zero-extended in_product, count=1, overflow=0.
REQ-018 SHALL, on an accepted beat in ACCUM, set acc=(acc+in_product) mod 2^ACC_W, count=count+1, overflow|=carry out of bit ACC_W-1.
REQ-019 SHALL treat a beat as terminating when in_last=1 or when it is the N_TERMS-th accepted beat.
REQ-020 SHALL, on a terminating beat, capture the updated acc/count/overflow into out_sum/out_count/out_overflow and enter HOLD; otherwise enter or stay in ACCUM.
REQ-021 SHALL assert out_valid exactly in HOLD, i.e. the cycle after the terminating beat (latency 1 cycle).
REQ-022 SHALL hold out_sum, out_count, out_overflow stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on out_valid && out_ready, return to IDLE; in_ready rises in the following cycle (no same-cycle bypass).
REQ-024 SHALL stay in its current state with no change to acc/count in IDLE/ACCUM cycles when in_valid=0.
REQ-025 SHALL ignore in_last and in_product whenever in_valid=0 or in_ready=0.
REQ-026 SHALL, with N_TERMS=1, terminate on every accepted beat regardless of in_last.
REQ-027 SHALL keep out_sum/out_count/out_overflow at their last captured values in IDLE/ACCUM; only out_valid qualifies them.

Reset
REQ-028 SHALL, on rst=1, immediately (asynchronously) enter IDLE and clear acc, count, out_sum, out_count, out_overflow, out_valid to 0; in_ready=1 after reset release.
REQ-029 SHALL discard any partial accumulation or pending HOLD result when rst asserts mid-operation; no result is emitted for it.
REQ-030 SHALL accept a beat on the first rising clk edge with rst=0.

Verification
REQ-031 SHALL cover: defaults, 4 beats of 225 (15x15), in_last=0 throughout, out_ready=1 -> out_valid one cycle after 4th beat, out_sum=900, out_count=4, out_overflow=0.
REQ-032 SHALL cover: beats 6, 20, in_last=1 on second -> out_sum=26, out_count=2; N_TERMS limit not reached.
REQ-033 SHALL cover: ACC_W=8, beats 225, 225, in_last on second -> out_sum=194, out_overflow=1; next dot product of single beat 10 -> out_sum=10, out_overflow=0.
REQ-034 SHALL cover: result pending with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable, no beats consumed; out_ready=1 -> IDLE, next beat accepted one cycle later.
REQ-035 SHALL cover: in_valid gaps (1 beat, 3 idle cycles, 1 beat with in_last) -> sum of both beats only, out_count=2.
REQ-036 SHALL cover: rst pulsed asynchronously after 2 of 4 beats (values 100, 50) -> out_valid=0 immediately; following 4 beats of 1 -> out_sum=4, out_count=4.
